// File: rtl/dmem_responder_if.sv
// ---------------------------------------------------------------------------
// dmem_responder_if
//
// Purpose:
//   Bundles the CPU data-memory load/store handshake into one interface.
//   The core (or a bench) drives the request side through the master modport.
//   The memory responder answers through the slave modport.
//
// Signal summary:
//   req    master->slave  1   access request; held with we/addr/wdata stable until ready
//   we     master->slave  1   1 = store, 0 = load
//   addr   master->slave  32  byte address
//   wdata  master->slave  32  store data
//   rdata  slave->master  32  load data, meaningful only while ready=1
//   ready  slave->master  1   one-cycle completion pulse
//   err    slave->master  1   pulses with ready for an out-of-range or misaligned access
// ---------------------------------------------------------------------------
interface dmem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  // Requester side: drives the access and waits for the completion pulse.
  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  rdata,
    input  ready,
    input  err
  );

  // Memory side: samples the access and produces the completion pulse.
  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output rdata,
    output ready,
    output err
  );
endinterface

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Purpose:
//   This module is the memory side of the CPU load/store port.
//   It services word loads and stores from an internal RAM and inserts a fixed
//   number of wait states before each completion.
//   It also watches one memory-mapped result address. A store there latches the
//   stored value and raises done/pass, so a finished program is visible in
//   hardware.
//
// Ports:
//   clk     in   1   single clock, rising-edge
//   reset   in   1   synchronous, active-high
//   bus     slave modport of dmem_responder_if (req/we/addr/wdata in,
//                    rdata/ready/err out)
//   done    out  1   sticky, set by the first store to RESULT_ADDR
//   pass    out  1   most recent result store equalled EXPECT
//   result  out  32  most recent value stored to RESULT_ADDR
//
// Parameters:
//   DEPTH        RAM size in 32-bit words (word index = addr[31:2])
//   WAIT_CYCLES  wait states before ready, 0..15
//   RESULT_ADDR  byte address of the result register
//   EXPECT       result value that sets pass
//
// Optional feature:
//   DMEM_ALIGN_CHECK_EN
//     Defined: an address with addr[1:0] != 0 is reported through err. The
//              store is dropped and the load returns 0.
//     Undefined: addr[1:0] is ignored.
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int          DEPTH       = 64,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] RESULT_ADDR = 32'h64,
  parameter logic [31:0] EXPECT      = 32'd7
) (
  input  logic               clk,
  input  logic               reset,
  dmem_responder_if.slave    bus,
  output logic               done,
  output logic               pass,
  output logic [31:0]        result
);

  localparam int          IDX_W         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W       = 32'(DEPTH);
  localparam logic [3:0]  WAIT_CNT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e      state_q,     state_d;
  logic [3:0]  waitCnt_q,   waitCnt_d;
  logic        we_q,        we_d;
  logic [31:0] addr_q,      addr_d;
  logic [31:0] wdata_q,     wdata_d;
  logic [31:0] rdataHold_q, rdataHold_d;
  logic        done_q,      done_d;
  logic        pass_q,      pass_d;
  logic [31:0] result_q,    result_d;

  logic [31:0] mem [DEPTH];

  logic [31:0]      wordIdxExt;
  logic [IDX_W-1:0] memIdx;
  logic             outOfRange;
  logic             misaligned;
  logic             accessErr;
  logic             isResultAddr;
  logic [31:0]      readVal;
  logic             memWrite;
  logic             inResp;

  // Decode the latched access. The range test uses the whole word index, so a
  // high address can never alias onto a low RAM word through the truncated
  // memIdx.
  always_comb begin
    wordIdxExt   = {2'b00, addr_q[31:2]};
    memIdx       = addr_q[IDX_W+1:2];
    outOfRange   = (wordIdxExt >= DEPTH_W);
`ifdef DMEM_ALIGN_CHECK_EN
    misaligned   = |addr_q[1:0];
`else
    misaligned   = 1'b0;
`endif
    accessErr    = outOfRange | misaligned;
    isResultAddr = (addr_q == RESULT_ADDR);
    inResp       = (state_q == S_RESP);
    readVal      = accessErr ? 32'h0 : mem[memIdx];
    memWrite     = inResp & we_q & ~accessErr;
  end

  // Next-state logic for the IDLE -> WAIT -> RESP handshake.
  // Inputs are captured only in IDLE, so the requester may change req during WAIT
  // without affecting the access in flight.
  // The result register commits in the same step as the RAM write, on the edge
  // that leaves RESP.
  always_comb begin
    state_d     = state_q;
    waitCnt_d   = waitCnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdataHold_d = rdataHold_q;
    done_d      = done_q;
    pass_d      = pass_q;
    result_d    = result_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          we_d      = bus.we;
          addr_d    = bus.addr;
          wdata_d   = bus.wdata;
          waitCnt_d = WAIT_CNT_INIT;
          state_d   = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end
      end

      S_WAIT: begin
        if (waitCnt_q != 4'd0) begin
          waitCnt_d = waitCnt_q - 4'd1;
        end
        if (waitCnt_q <= 4'd1) begin
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        state_d     = S_IDLE;
        rdataHold_d = readVal;
        if (we_q && isResultAddr) begin
          result_d = wdata_q;
          pass_d   = (wdata_q == EXPECT);
          done_d   = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. A synchronous reset abandons any access in
  // flight, so the access never reaches RESP and never produces a RAM write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      waitCnt_q   <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      rdataHold_q <= 32'h0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      result_q    <= 32'h0;
    end else begin
      state_q     <= state_d;
      waitCnt_q   <= waitCnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdataHold_q <= rdataHold_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      result_q    <= result_d;
    end
  end

  // RAM write port. Reset does not clear the contents. The write is still gated
  // by reset, so an access that is interrupted while in RESP cannot commit.
  always_ff @(posedge clk) begin
    if (!reset && memWrite) begin
      mem[memIdx] <= wdata_q;
    end
  end

  // While ready is high, rdata shows the live read. At all other times it holds
  // the value captured during the last response.
  always_comb begin
    bus.ready = inResp;
    bus.err   = inResp & accessErr;
    bus.rdata = inResp ? readVal : rdataHold_q;
    done      = done_q;
    pass      = pass_q;
    result    = result_q;
  end

endmodule
